// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI-lite arbiters.
// Imported by the read arbiter and its round-robin picker.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  localparam logic [1:0] AXIL_RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker, purely combinational.
// On contention the port that did not win last time is chosen.
module rr_arb2
  import axil_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // pick a winner from the current requests and the previous grant
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_FETCH;
    case (req)
      2'b01:   gnt_idx = PORT_FETCH;
      2'b10:   gnt_idx = PORT_LSU;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Two-master AXI-lite read arbiter sharing one slave read port.
// One outstanding read; AR is registered, R is a combinational mux.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axil_rd_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,

  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  arb_state_e state_q, state_d;

  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            prot_q, prot_d;

  logic gnt_valid;
  logic gnt_idx;
  logic rready_g;
  logic r_hs;

  rr_arb2 u_rr (
    .req       ({s1_axil_arvalid, s0_axil_arvalid}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign rready_g = (grant_q == PORT_LSU) ? s1_axil_rready
                                          : s0_axil_rready;

  assign r_hs = (state_q == DATA) && m_axil_rvalid && rready_g;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_valid) state_d = ADDR;
      ADDR: if (m_axil_arready) state_d = DATA;
      DATA: if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant, fairness and captured request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= PORT_FETCH;
      last_q  <= PORT_LSU;
      addr_q  <= '0;
      prot_q  <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
    end
  end

  // capture the winner in IDLE, remember it once its read completes
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    prot_d  = prot_q;
    if ((state_q == IDLE) && gnt_valid) begin
      grant_d = gnt_idx;
      if (gnt_idx == PORT_LSU) begin
        addr_d = s1_axil_araddr;
        prot_d = s1_axil_arprot;
      end else begin
        addr_d = s0_axil_araddr;
        prot_d = s0_axil_arprot;
      end
    end
    if (r_hs) begin
      last_d = grant_q;
    end
  end

  // outputs: arready grant in IDLE, AR drive in ADDR, R mux in DATA
  always_comb begin
    s0_axil_arready = 1'b0;
    s1_axil_arready = 1'b0;
    s0_axil_rdata   = '0;
    s1_axil_rdata   = '0;
    s0_axil_rresp   = AXIL_RESP_OKAY;
    s1_axil_rresp   = AXIL_RESP_OKAY;
    s0_axil_rvalid  = 1'b0;
    s1_axil_rvalid  = 1'b0;
    m_axil_araddr   = '0;
    m_axil_arprot   = '0;
    m_axil_arvalid  = 1'b0;
    m_axil_rready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gates arready so a request is never acked
        // on an edge that does not capture it
        if (gnt_valid && !rst) begin
          if (gnt_idx == PORT_LSU) s1_axil_arready = 1'b1;
          else                     s0_axil_arready = 1'b1;
        end
      end
      ADDR: begin
        m_axil_arvalid = 1'b1;
        m_axil_araddr  = addr_q;
        m_axil_arprot  = prot_q;
      end
      DATA: begin
        m_axil_rready = rready_g;
        if (grant_q == PORT_LSU) begin
          s1_axil_rdata  = m_axil_rdata;
          s1_axil_rresp  = m_axil_rresp;
          s1_axil_rvalid = m_axil_rvalid;
        end else begin
          s0_axil_rdata  = m_axil_rdata;
          s0_axil_rresp  = m_axil_rresp;
          s0_axil_rvalid = m_axil_rvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter.
// The bench plays both requesters and the RAM slave.
module tb_axil_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] s0_araddr, s1_araddr;
  logic [2:0]  s0_arprot, s1_arprot;
  logic        s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;

  int total = 0;
  int bad   = 0;
  int g0, g1;
  logic last_m;

  axil_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .s0_axil_araddr  (s0_araddr),
    .s0_axil_arprot  (s0_arprot),
    .s0_axil_arvalid (s0_arvalid),
    .s0_axil_arready (s0_arready),
    .s0_axil_rdata   (s0_rdata),
    .s0_axil_rresp   (s0_rresp),
    .s0_axil_rvalid  (s0_rvalid),
    .s0_axil_rready  (s0_rready),
    .s1_axil_araddr  (s1_araddr),
    .s1_axil_arprot  (s1_arprot),
    .s1_axil_arvalid (s1_arvalid),
    .s1_axil_arready (s1_arready),
    .s1_axil_rdata   (s1_rdata),
    .s1_axil_rresp   (s1_rresp),
    .s1_axil_rvalid  (s1_rvalid),
    .s1_axil_rready  (s1_rready),
    .m_axil_araddr   (m_araddr),
    .m_axil_arprot   (m_arprot),
    .m_axil_arvalid  (m_arvalid),
    .m_axil_arready  (m_arready),
    .m_axil_rdata    (m_rdata),
    .m_axil_rresp    (m_rresp),
    .m_axil_rvalid   (m_rvalid),
    .m_axil_rready   (m_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h13;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_arvalid"}, m_arvalid, 0);
    chk({tag, "_araddr"},  m_araddr,  0);
    chk({tag, "_arprot"},  m_arprot,  0);
    chk({tag, "_ardy0"},   s0_arready, 0);
    chk({tag, "_ardy1"},   s1_arready, 0);
    chk({tag, "_rv0"},     s0_rvalid, 0);
    chk({tag, "_rv1"},     s1_rvalid, 0);
    chk({tag, "_rd0"},     s0_rdata,  0);
    chk({tag, "_rd1"},     s1_rdata,  0);
    chk({tag, "_rr0"},     s0_rresp,  0);
    chk({tag, "_rr1"},     s1_rresp,  0);
    chk({tag, "_mrrdy"},   m_rready,  0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    m_arready = 1'b0;
    m_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
    last_m = 1'b1;
  endtask

  // Run one transaction from its IDLE cycle to its R handshake.
  // Entered just after a rising edge with the arvalids already set.
  task automatic serve_one(input int ar_st, input int rdly,
                           input int r_st, input logic [1:0] resp,
                           input bit rearm);
    logic w;
    logic [31:0] ea, ed, drv;
    logic [2:0] ep;
    logic rdy, sv;
    logic [31:0] sd;
    logic [1:0] sr;
    int n;
    w  = (s0_arvalid && s1_arvalid) ? ~last_m : s1_arvalid;
    ea = w ? s1_araddr : s0_araddr;
    ep = w ? s1_arprot : s0_arprot;
    ed = ram_word(ea);
    @(negedge clk);
    chk("ar_win",  w ? s1_arready : s0_arready, 1);
    chk("ar_lose", w ? s0_arready : s1_arready, 0);
    chk("m_arvalid_idle", m_arvalid, 0);
    if (s0_arready) g0++;
    if (s1_arready) g1++;
    step();
    if (rearm) begin
      if (w) s1_araddr = $urandom_range(255) << 2;
      else   s0_araddr = $urandom_range(255) << 2;
    end else begin
      if (w) s1_arvalid = 1'b0;
      else   s0_arvalid = 1'b0;
    end
    for (int i = 0; i <= ar_st; i++) begin
      m_arready = (i == ar_st);
      @(negedge clk);
      chk("m_arvalid", m_arvalid, 1);
      chk("m_araddr", m_araddr, ea);
      chk("m_arprot", m_arprot, ep);
      chk("ar_addr_0", {s1_arready, s0_arready}, 0);
      chk("m_rready_addr", m_rready, 0);
      step();
    end
    m_arready = 1'b0;
    n = rdly + r_st + 1;
    for (int i = 0; i < n; i++) begin
      m_rvalid = (i >= rdly);
      drv = m_rvalid ? ed : $urandom;
      m_rdata = drv;
      m_rresp = resp;
      rdy = (i < rdly) ? 1'($urandom_range(1)) : (i == n - 1);
      if (w) begin
        s1_rready = rdy;
        s0_rready = 1'($urandom_range(1));
      end else begin
        s0_rready = rdy;
        s1_rready = 1'($urandom_range(1));
      end
      @(negedge clk);
      sv = w ? s1_rvalid : s0_rvalid;
      sd = w ? s1_rdata : s0_rdata;
      sr = w ? s1_rresp : s0_rresp;
      chk("r_valid", sv, m_rvalid);
      chk("r_data", sd, drv);
      chk("r_resp", sr, resp);
      chk("m_rready", m_rready, rdy);
      chk("other_rvalid", w ? s0_rvalid : s1_rvalid, 0);
      chk("other_rdata", w ? s0_rdata : s1_rdata, 0);
      chk("m_arvalid_data", m_arvalid, 0);
      step();
    end
    m_rvalid = 1'b0;
    s0_rready = 1'b0;
    s1_rready = 1'b0;
    last_m = w;
  endtask

  initial begin
    rst = 1'b1;
    s0_araddr = 0; s1_araddr = 0;
    s0_arprot = 0; s1_arprot = 0;
    s0_arvalid = 0; s1_arvalid = 0;
    s0_rready = 0; s1_rready = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    g0 = 0; g1 = 0;
    do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk_quiet_outputs("reset");
    step();
    rst = 1'b0;
    last_m = 1'b1;

    // single fetch
    s0_araddr = 32'h10;
    s0_arprot = 3'b100;
    s0_arvalid = 1'b1;
    serve_one(0, 0, 0, 2'b00, 0);
    @(negedge clk);
    chk_quiet_outputs("idle_after");
    step();

    // simultaneous from reset
    do_reset();
    s0_araddr = 32'h0;   s0_arprot = 3'($urandom);
    s1_araddr = 32'h100; s1_arprot = 3'($urandom);
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    g0 = 0; g1 = 0;
    serve_one(0, 0, 0, 2'b00, 0);
    chk("sim_first_p0", g0, 1);
    serve_one($urandom_range(2), $urandom_range(2), 0, 2'b00, 0);
    chk("sim_second_p1", g1, 1);

    // fairness with continuous requests and random stalls
    g0 = 0; g1 = 0;
    s0_araddr = $urandom_range(255) << 2;
    s1_araddr = $urandom_range(255) << 2;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s0_arprot = 3'($urandom);
      s1_arprot = 3'($urandom);
      serve_one($urandom_range(3), $urandom_range(3),
                $urandom_range(2), 2'($urandom_range(1)), 1);
    end
    chk("fair_p0", g0, 4);
    chk("fair_p1", g1, 4);
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    step();

    // back-pressure on both AR and R
    s1_araddr = 32'h2468;
    s1_arvalid = 1'b1;
    serve_one(5, 1, 3, 2'b00, 0);

    // error response on port 1, then normal read on port 0
    s1_araddr = 32'h40;
    s1_arvalid = 1'b1;
    serve_one(1, 0, 0, 2'b10, 0);
    s0_araddr = 32'h44;
    s0_arvalid = 1'b1;
    serve_one(0, 2, 1, 2'b00, 0);

    // reset while in ADDR
    s0_araddr = 32'h80; s1_araddr = 32'h84;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    m_arready = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_addr_arvalid", m_arvalid, 1);
    step();
    @(negedge clk);
    chk_quiet_outputs("rst_mid");
    step();
    rst = 1'b0;
    last_m = 1'b1;
    g0 = 0; g1 = 0;
    serve_one(0, 0, 0, 2'b00, 0);
    chk("post_rst_p0", g0, 1);
    serve_one(0, 1, 0, 2'b00, 0);
    chk("post_rst_p1", g1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
